commit_halt_monitor: RTL and testbench

- Synthesizable sequential monitor on the writeback (commit) end of xgriscv_pipeline.
- Consumes the retired-instruction stream (valid + PC) and counts cycles and retirements.
- Raises a sticky halt with a cause code on an end-of-program PC, a self-loop, or a cycle-budget timeout.
- Gives simulation benches and FPGA top levels one stop signal instead of ad-hoc PC polling.

---
 rtl/commit_if.sv | 9 +
 rtl/commit_halt_monitor.sv | 187 ++++++++++++++++++
 tb/tb_commit_halt_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/commit_if.sv
// Retired-instruction stream from the writeback stage into commit_halt_monitor.
// The stream is valid-only: commit_pc is meaningful only while commit_valid is high, and there is no ready (the monitor never stalls commits).
interface commit_if;
  logic        commit_valid;
  logic [31:0] commit_pc;

  modport master (output commit_valid, output commit_pc);
  modport slave  (input  commit_valid, input  commit_pc);
endinterface

// File: rtl/commit_halt_monitor.sv
// Commit-side run monitor: counts cycles/retirements and raises a sticky halt on END_PC, a self-loop or a cycle-budget timeout.
// Optional commit-PC history FIFO is enabled by defining COMMIT_TRACE_FIFO_EN.
module commit_halt_monitor #(
  parameter logic [31:0] END_PC      = 32'h0C000048,
  parameter int unsigned MAX_CYCLES  = 50,
  parameter int unsigned LOOP_LIMIT  = 4,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  commit_if.slave                      commit,
  output logic                         halt,
  output logic [1:0]                   status,
  output logic [31:0]                  cycle_cnt,
  output logic [31:0]                  retire_cnt,
  input  logic                         trace_rd_en,
  output logic [31:0]                  trace_rd_data,
  output logic                         trace_empty,
  output logic [$clog2(TRACE_DEPTH):0] trace_count
);

  localparam int unsigned AW      = $clog2(TRACE_DEPTH);
  localparam logic [31:0] MAX_C   = 32'(MAX_CYCLES);
  localparam logic [31:0] LOOP_C  = 32'(LOOP_LIMIT);

  localparam logic [1:0] ST_RUNNING = 2'b00;
  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_LOOP    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] loop_cnt_q, loop_cnt_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic        pass_ev, loop_ev, tmo_ev;
  logic        accept;

  // A commit is only accepted (counted, traced) while running.
  assign accept = (state_q == S_RUN) && commit.commit_valid;

  always_comb begin
    state_d      = state_q;
    halt_d       = halt_q;
    status_d     = status_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    loop_cnt_d   = loop_cnt_q;
    last_pc_d    = last_pc_q;
    pass_ev      = 1'b0;
    loop_ev      = 1'b0;
    tmo_ev       = 1'b0;

    if (state_q == S_RUN) begin
      if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (commit.commit_valid) begin
        if (retire_cnt_q != 32'hFFFF_FFFF) retire_cnt_d = retire_cnt_q + 32'd1;
        last_pc_d  = commit.commit_pc;
        // retire_cnt==0 means last_pc holds the reset value, not a real commit.
        loop_cnt_d = (commit.commit_pc == last_pc_q && retire_cnt_q != 32'd0) ?
                     loop_cnt_q + 32'd1 : 32'd1;
        pass_ev    = (commit.commit_pc == END_PC);
        loop_ev    = (loop_cnt_d == LOOP_C);
      end
      tmo_ev = (MAX_C != 32'd0) && (cycle_cnt_d == MAX_C);

      if (pass_ev || loop_ev || tmo_ev) begin
        state_d = S_HALT;
        halt_d  = 1'b1;
        if (pass_ev)      status_d = ST_PASS;
        else if (loop_ev) status_d = ST_LOOP;
        else              status_d = ST_TIMEOUT;
      end
    end

    if (clear) begin
      state_d      = S_RUN;
      halt_d       = 1'b0;
      status_d     = ST_RUNNING;
      cycle_cnt_d  = 32'd0;
      retire_cnt_d = 32'd0;
      loop_cnt_d   = 32'd0;
      last_pc_d    = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_RUN;
      halt_q       <= 1'b0;
      status_q     <= ST_RUNNING;
      cycle_cnt_q  <= 32'd0;
      retire_cnt_q <= 32'd0;
      loop_cnt_q   <= 32'd0;
      last_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      halt_q       <= halt_d;
      status_q     <= status_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      loop_cnt_q   <= loop_cnt_d;
      last_pc_q    <= last_pc_d;
    end
  end

  assign halt       = halt_q;
  assign status     = status_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;

`ifdef COMMIT_TRACE_FIFO_EN
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TRACE_DEPTH);

  logic [31:0]   mem_q [TRACE_DEPTH];
  logic [31:0]   mem_d [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          pop;

  assign pop = trace_rd_en && (cnt_q != '0);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;

    // The pop reads the pre-edge head, so a simultaneous push into a full FIFO cannot clobber it.
    if (pop) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
    if (accept) begin
      mem_d[wr_ptr_q] = commit.commit_pc;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (cnt_q == DEPTH_C && !pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (accept && !pop && cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
    else if (pop && !accept)                cnt_d = cnt_q - 1'b1;

    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      rd_data_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(TRACE_DEPTH); i++) mem_q[i] <= 32'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= 32'd0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign trace_rd_data = rd_data_q;
  assign trace_empty   = (cnt_q == '0);
  assign trace_count   = cnt_q;
`else
  logic unused_trace_rd_en;
  logic unused_accept;
  assign unused_trace_rd_en = trace_rd_en;
  assign unused_accept      = accept;
  assign trace_rd_data      = 32'd0;
  assign trace_empty        = 1'b1;
  assign trace_count        = '0;
`endif

endmodule

// File: tb/tb_commit_halt_monitor.sv
// Directed bench for commit_halt_monitor: PASS, timeout, self-loop, priority, clear/reset and trace history.
module tb_commit_halt_monitor;
  localparam logic [31:0] END_PC = 32'h0C000048;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic        halt;
  logic [1:0]  status;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
  logic        trace_rd_en;
  logic [31:0] trace_rd_data;
  logic        trace_empty;
  logic [3:0]  trace_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  commit_if cif ();

  commit_halt_monitor #(
    .END_PC(END_PC), .MAX_CYCLES(50), .LOOP_LIMIT(4), .TRACE_DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .commit(cif.slave),
    .halt(halt), .status(status), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .trace_rd_en(trace_rd_en), .trace_rd_data(trace_rd_data),
    .trace_empty(trace_empty), .trace_count(trace_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, outputs sampled there
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cif.commit_valid = 1'b0;
    cif.commit_pc    = 32'd0;
    clear            = 1'b0;
    trace_rd_en      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic commit(input logic [31:0] pc);
    cif.commit_valid = 1'b1;
    cif.commit_pc    = pc;
    tick();
    cif.commit_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_halt"},   {31'd0, halt}, 32'd0);
    check({tag, "_status"}, {30'd0, status}, 32'd0);
    check({tag, "_cycle"},  cycle_cnt, 32'd0);
    check({tag, "_retire"}, retire_cnt, 32'd0);
    check({tag, "_tdata"},  trace_rd_data, 32'd0);
    check({tag, "_tempty"}, {31'd0, trace_empty}, 32'd1);
    check({tag, "_tcount"}, {28'd0, trace_count}, 32'd0);
  endtask

  initial begin
    // reset state
    idle();
    rstn = 1'b0;
    #12;
    check_all_zero("reset");
    tick();
    rstn = 1'b1;

    // PASS on third commit, commits start at the first edge after reset release
    cif.commit_valid = 1'b1;
    cif.commit_pc = 32'h0C000000; tick();
    cif.commit_pc = 32'h0C000004; tick();
    check("pass_not_yet", {31'd0, halt}, 32'd0);
    cif.commit_pc = END_PC;       tick();
    check("pass_halt",   {31'd0, halt}, 32'd1);
    check("pass_status", {30'd0, status}, 32'd1);
    check("pass_retire", retire_cnt, 32'd3);
    check("pass_cycle",  cycle_cnt, 32'd3);
    // sticky: further commits ignored
    cif.commit_pc = 32'h0C000100; tick();
    cif.commit_pc = 32'h0C000104; tick();
    cif.commit_valid = 1'b0;
    check("pass_sticky_retire", retire_cnt, 32'd3);
    check("pass_sticky_status", {30'd0, status}, 32'd1);

    // timeout with no commits
    do_reset();
    repeat (49) tick();
    check("tmo_pre_halt",  {31'd0, halt}, 32'd0);
    check("tmo_pre_cycle", cycle_cnt, 32'd49);
    tick();
    check("tmo_halt",   {31'd0, halt}, 32'd1);
    check("tmo_status", {30'd0, status}, 32'd3);
    check("tmo_cycle",  cycle_cnt, 32'd50);
    repeat (10) tick();
    check("tmo_frozen", cycle_cnt, 32'd50);

    // self-loop
    do_reset();
    commit(32'h0C000010);
    repeat (3) commit(32'h0C000020);
    check("loop_not_yet", {31'd0, halt}, 32'd0);
    commit(32'h0C000020);
    check("loop_halt",   {31'd0, halt}, 32'd1);
    check("loop_status", {30'd0, status}, 32'd2);
    check("loop_retire", retire_cnt, 32'd5);

    // PASS beats TIMEOUT on the same edge, then stays frozen
    do_reset();
    repeat (49) tick();
    commit(END_PC);
    check("prio_status", {30'd0, status}, 32'd1);
    check("prio_cycle",  cycle_cnt, 32'd50);
    check("prio_retire", retire_cnt, 32'd1);
    for (int i = 0; i < 5; i++) commit(32'h0C000200 + 32'(4 * i));
    check("prio_sticky_cycle",  cycle_cnt, 32'd50);
    check("prio_sticky_retire", retire_cnt, 32'd1);
    check("prio_sticky_status", {30'd0, status}, 32'd1);

    // clear while halted
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_halt",   {31'd0, halt}, 32'd0);
    check("clear_status", {30'd0, status}, 32'd0);
    check("clear_cycle",  cycle_cnt, 32'd0);
    check("clear_retire", retire_cnt, 32'd0);
    tick();
    check("clear_running", cycle_cnt, 32'd1);

    // async reset mid-cycle after 10 commits
    for (int i = 0; i < 10; i++) commit(32'h0C000300 + 32'(4 * i));
    check("mid_retire", retire_cnt, 32'd10);
    check("mid_cycle",  cycle_cnt, 32'd11);
    #3;
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rstn = 1'b1;

    // trace history: 10 distinct commits then 9 pops
    for (int i = 0; i < 10; i++) begin
      commit(32'h0C000400 + 32'(4 * i));
`ifdef COMMIT_TRACE_FIFO_EN
      exp_q.push_back(32'h0C000400 + 32'(4 * i));
      if (exp_q.size() > 8) void'(exp_q.pop_front());
`endif
    end
`ifdef COMMIT_TRACE_FIFO_EN
    check("trace_count_full", {28'd0, trace_count}, 32'd8);
    check("trace_not_empty",  {31'd0, trace_empty}, 32'd0);
    trace_rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("trace_pop_data", trace_rd_data, exp_q.pop_front());
    end
    check("trace_empty_after8", {31'd0, trace_empty}, 32'd1);
    check("trace_count_after8", {28'd0, trace_count}, 32'd0);
    tick();
    trace_rd_en = 1'b0;
    check("trace_pop9_hold", trace_rd_data, 32'h0C000424);
`else
    check("trace_off_count", {28'd0, trace_count}, 32'd0);
    trace_rd_en = 1'b1;
    repeat (9) tick();
    trace_rd_en = 1'b0;
    check("trace_off_empty", {31'd0, trace_empty}, 32'd1);
    check("trace_off_data",  trace_rd_data, 32'd0);
    check("trace_off_count2", {28'd0, trace_count}, 32'd0);
`endif
    check("trace_retire", retire_cnt, 32'd10);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
